// File: rtl/pkt_fifo_ctrl.sv
// Packet FIFO sequencer over an external dual-port memory with a 1-cycle read latency.
// Optional macro PKT_FIFO_CTRL_FILL_EN adds the registered fill_o committed-byte count.
module pkt_fifo_ctrl #(
    parameter int  DEPTH    = 512,
    parameter int  DATA_WID = 8,
    localparam int ADDR_WID = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wValid_i,
    input  logic [DATA_WID-1:0] wData_i,
    output logic                wReady_o,
    input  logic                wCommit_i,
    input  logic                wRevert_i,
    output logic                rValid_o,
    output logic [DATA_WID-1:0] rData_o,
    input  logic                rReady_i,
    output logic                mem_wEn_o,
    output logic [ADDR_WID-1:0] mem_wAddr_o,
    output logic [DATA_WID-1:0] mem_wData_o,
    output logic [ADDR_WID-1:0] mem_rAddr_o,
    input  logic [DATA_WID-1:0] mem_rData_i
`ifdef PKT_FIFO_CTRL_FILL_EN
    ,
    output logic [ADDR_WID:0]   fill_o
`endif
);

    localparam int                 PTR_WID   = ADDR_WID + 1;
    localparam logic [PTR_WID-1:0] FULL_DIST = PTR_WID'(DEPTH);

    logic [PTR_WID-1:0] w_ptr_q, w_ptr_d;
    logic [PTR_WID-1:0] c_ptr_q, c_ptr_d;
    logic [PTR_WID-1:0] r_ptr_q, r_ptr_d;
    logic               r_valid_q, r_valid_d;
    logic [PTR_WID-1:0] w_ptr_inc;
    logic               w_hs;
    logic               pop;

    // Uncommitted bytes count against capacity; a same-cycle pop frees space only next cycle.
    assign wReady_o  = (w_ptr_q - r_ptr_q) != FULL_DIST;
    assign w_hs      = wValid_i & wReady_o & ~rst_i;
    assign pop       = r_valid_q & rReady_i;
    assign w_ptr_inc = w_ptr_q + PTR_WID'(w_hs);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_ptr_d = w_ptr_inc;
        c_ptr_d = c_ptr_q;
        if (wRevert_i) begin
            w_ptr_d = c_ptr_q;
        end else if (wCommit_i) begin
            c_ptr_d = w_ptr_inc;
        end

        r_ptr_d   = r_ptr_q + PTR_WID'(pop);
        // Compared against the pre-edge committed pointer so a byte is never read in its write cycle.
        r_valid_d = r_ptr_d != c_ptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst_i) begin
            w_ptr_q   <= '0;
            c_ptr_q   <= '0;
            r_ptr_q   <= '0;
            r_valid_q <= 1'b0;
        end else begin
            w_ptr_q   <= w_ptr_d;
            c_ptr_q   <= c_ptr_d;
            r_ptr_q   <= r_ptr_d;
            r_valid_q <= r_valid_d;
        end
    end

    assign mem_wEn_o   = w_hs;
    assign mem_wAddr_o = w_ptr_q[ADDR_WID-1:0];
    assign mem_wData_o = wData_i;
    // Addressing the next head keeps the address, and hence mem output, stable while stalled.
    assign mem_rAddr_o = r_ptr_d[ADDR_WID-1:0];
    assign rValid_o    = r_valid_q;
    assign rData_o     = mem_rData_i;

`ifdef PKT_FIFO_CTRL_FILL_EN
    logic [PTR_WID-1:0] fill_q, fill_d;

    always_comb begin
        fill_d = c_ptr_d - r_ptr_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign fill_o = fill_q;
`endif

endmodule
